controle_enchimento: RTL and testbench
======================================

# controle_enchimento

Automatic fill controller for the tank inlet valve. It debounces the low-level and high-level float sensors and runs a Moore state machine that drives the valve's `abre_auto` / `fecha_auto` inputs. The state machine enforces a minimum closed pause between fills, a maximum fill time, and sensor-consistency checking. The operator `manual` switch overrides the block, which then releases both automatic commands.

## Interface
- `DEBOUNCE`, default 4: consecutive mismatching cycles before a filtered sensor value changes (≥2).
- `T_PAUSA`, default 100: cycles spent in ESPERA (≥1).
- `T_ENCHER`, default 1000: maximum cycles in ENCHENDO before a timeout fault (≥1).
- `clock  in  1`: single clock; all state updates on the rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `nivel_baixo  in  1`: raw low sensor; 1 = water at or above the low mark; asynchronous.
- `nivel_alto  in  1`: raw high sensor; 1 = water at or above the high mark; asynchronous.
- `manual  in  1`: operator override switch; asynchronous.
- `reconhece  in  1`: fault acknowledge, level-sensitive; asynchronous.
- `abre_auto  out  1`: open command to the valve.
- `fecha_auto  out  1`: close command to the valve.
- `alarme  out  1`: 1 while in FALHA.
- `falha_cod  out  2`: fault code. 00 none, 01 fill timeout, 10 sensor inconsistency.
- `estado  out  3`: current state. 000 ESPERA, 001 OCIOSO, 010 ENCHENDO, 011 FALHA, 100 MANUAL.

## Operation
- All four async inputs pass through 2-flop synchronizers. Only `nivel_baixo` and `nivel_alto` are then debounced.
- Debounce, per sensor:
  - If synced value == filtered value, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE-1 with the mismatch still present, the filtered value takes the synced value and the counter clears.
  - Filtered values reset to 0.
- Inconsistency condition: filtered alto=1 and filtered baixo=0.
- A single counter, sized for max(T_PAUSA, T_ENCHER), clears on every state change.
- Transition priority, every state: `manual`=1 → MANUAL; then the state-specific rules below.
- ESPERA:
  - Count up. On the edge where count==T_PAUSA-1, go to FALHA(10) if inconsistent, else ENCHENDO if baixo=0, else OCIOSO.
- OCIOSO:
  - inconsistent → FALHA(10).
  - baixo=0 → ENCHENDO.
  - Otherwise stay.
- ENCHENDO:
  - inconsistent → FALHA(10).
  - else alto=1 → ESPERA.
  - else count==T_ENCHER-1 → FALHA(01).
  - else count up.
  - Level reached beats a simultaneous timeout.
- FALHA:
  - Stay until `reconhece`=1 and no inconsistency, then go to ESPERA and clear `falha_cod`.
  - `reconhece` while still inconsistent is ignored.
- MANUAL:
  - When `manual`=0, go to ESPERA.
  - `falha_cod` is retained through MANUAL. It clears only via acknowledge from FALHA.
  - Exception: entering MANUAL from FALHA and leaving to ESPERA clears it.
- Outputs are decoded from the registered state (Moore, glitch-free):
  - ENCHENDO: `abre_auto`=1, `fecha_auto`=0.
  - ESPERA, OCIOSO, FALHA: `abre_auto`=0, `fecha_auto`=1.
  - MANUAL: both 0.
  - `alarme` = (state==FALHA).
- `abre_auto` and `fecha_auto` are never both 1.

## Timing
- Reset values:
  - state ESPERA, so `estado`=000.
  - `abre_auto`=0, `fecha_auto`=1, `alarme`=0, `falha_cod`=00.
  - Counters and filtered sensors 0; synchronizers 0.
- Reset asserted mid-fill closes the valve immediately, through the async reset to ESPERA.
- Sensor latency: the filtered value changes DEBOUNCE+2 edges after the first edge that samples the new raw level. The state changes on the next edge, and outputs change with the state.
- A raw glitch shorter than DEBOUNCE cycles after synchronization never changes the filtered value.
- `manual` latency: the state enters or leaves MANUAL on the 3rd edge after the raw change.
- ESPERA lasts exactly T_PAUSA cycles. A timeout fault is entered after exactly T_ENCHER cycles in ENCHENDO.
- Counter arithmetic is unsigned. The counter never wraps because it clears on every transition.

## Test plan
- Params DEBOUNCE=4, T_PAUSA=8, T_ENCHER=32.
- Reset with both sensors 0:
  - `fecha_auto`=1, `estado`=000.
  - ENCHENDO entered after 8 cycles in ESPERA, `abre_auto`=1.
- Fill completes:
  - In ENCHENDO, raise `nivel_baixo` then `nivel_alto` (held).
  - Expect ESPERA 7 edges after `nivel_alto` is sampled, `abre_auto`=0, `fecha_auto`=1.
  - Then OCIOSO after 8 cycles.
- Timeout:
  - Hold both sensors 0 in ENCHENDO.
  - Expect FALHA on cycle 32: `alarme`=1, `falha_cod`=01, valve closed.
  - Pulse `reconhece` → ESPERA, `falha_cod`=00.
- Inconsistency:
  - In OCIOSO, drop `nivel_baixo` to 0 while `nivel_alto`=1.
  - Expect FALHA, `falha_cod`=10.
  - `reconhece` is ignored until the sensors are consistent.
- Glitch and override:
  - A 3-cycle `nivel_alto` pulse during ENCHENDO keeps the state in ENCHENDO.
  - `manual`=1 during ENCHENDO gives MANUAL with both commands 0.
  - Releasing `manual` gives ESPERA with `fecha_auto`=1.

Source files
------------

// File: rtl/controle_enchimento.sv
// Tank inlet fill controller: synchronizes and debounces the float sensors and drives
// the valve open/close commands from a Moore FSM with pause, fill timeout and fault handling.
`timescale 1ns/1ps
module controle_enchimento #(
    parameter int DEBOUNCE = 4,
    parameter int T_PAUSA  = 100,
    parameter int T_ENCHER = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       nivel_baixo,
    input  logic       nivel_alto,
    input  logic       manual,
    input  logic       reconhece,
    output logic       abre_auto,
    output logic       fecha_auto,
    output logic       alarme,
    output logic [1:0] falha_cod,
    output logic [2:0] estado
);

    localparam logic [2:0] ESPERA   = 3'b000;
    localparam logic [2:0] OCIOSO   = 3'b001;
    localparam logic [2:0] ENCHENDO = 3'b010;
    localparam logic [2:0] FALHA    = 3'b011;
    localparam logic [2:0] MANUAL   = 3'b100;

    localparam logic [1:0] COD_NADA    = 2'b00;
    localparam logic [1:0] COD_TEMPO   = 2'b01;
    localparam logic [1:0] COD_SENSOR  = 2'b10;

    localparam int T_MAX = (T_PAUSA > T_ENCHER) ? T_PAUSA : T_ENCHER;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam int DW    = $clog2(DEBOUNCE);

    localparam logic [CW-1:0] FIM_PAUSA  = CW'(T_PAUSA - 1);
    localparam logic [CW-1:0] FIM_ENCHER = CW'(T_ENCHER - 1);
    localparam logic [DW-1:0] DB_FIM     = DW'(DEBOUNCE - 1);

    // Bit order in the synchronizer: {reconhece, manual, nivel_alto, nivel_baixo}
    logic [3:0]          sync_1;
    logic [3:0]          sync_2;
    logic [1:0]          sinc;
    logic [1:0]          filt;
    logic [1:0][DW-1:0]  db_cnt;
    logic                filt_b;
    logic                filt_a;
    logic                man_s;
    logic                rec_s;
    logic                inconsistente;

    logic [CW-1:0]       cnt;
    logic [2:0]          estado_prox;
    logic [1:0]          cod_prox;
    logic                conta;

    assign sinc   = sync_2[1:0];
    assign man_s  = sync_2[2];
    assign rec_s  = sync_2[3];
    assign filt_b = filt[0];
    assign filt_a = filt[1];

    assign inconsistente = filt_a & ~filt_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {reconhece, manual, nivel_alto, nivel_baixo};
            sync_2 <= sync_1;
        end
    end

    // A sensor's filtered value flips only after DEBOUNCE consecutive mismatching samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt   <= '0;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sinc[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_FIM) begin
                    filt[i]   <= sinc[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        estado_prox = estado;
        cod_prox    = falha_cod;
        if (man_s) begin
            estado_prox = MANUAL;
        end else begin
            case (estado)
                ESPERA: begin
                    if (cnt == FIM_PAUSA) begin
                        if (inconsistente) begin
                            estado_prox = FALHA;
                            cod_prox    = COD_SENSOR;
                        end else if (!filt_b) begin
                            estado_prox = ENCHENDO;
                        end else begin
                            estado_prox = OCIOSO;
                        end
                    end
                end
                OCIOSO: begin
                    if (inconsistente) begin
                        estado_prox = FALHA;
                        cod_prox    = COD_SENSOR;
                    end else if (!filt_b) begin
                        estado_prox = ENCHENDO;
                    end
                end
                ENCHENDO: begin
                    if (inconsistente) begin
                        estado_prox = FALHA;
                        cod_prox    = COD_SENSOR;
                    end else if (filt_a) begin
                        estado_prox = ESPERA;
                    end else if (cnt == FIM_ENCHER) begin
                        estado_prox = FALHA;
                        cod_prox    = COD_TEMPO;
                    end
                end
                FALHA: begin
                    if (rec_s && !inconsistente) begin
                        estado_prox = ESPERA;
                        cod_prox    = COD_NADA;
                    end
                end
                MANUAL: begin
                    // A nonzero code here can only have been carried in from FALHA.
                    estado_prox = ESPERA;
                    cod_prox    = COD_NADA;
                end
                default: begin
                    estado_prox = ESPERA;
                    cod_prox    = COD_NADA;
                end
            endcase
        end
    end

    assign conta = (estado == ESPERA) || (estado == ENCHENDO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= ESPERA;
            falha_cod <= COD_NADA;
            cnt       <= '0;
        end else begin
            estado    <= estado_prox;
            falha_cod <= cod_prox;
            if (estado_prox != estado) begin
                cnt <= '0;
            end else if (conta) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign abre_auto  = (estado == ENCHENDO);
    assign fecha_auto = (estado == ESPERA) || (estado == OCIOSO) || (estado == FALHA);
    assign alarme     = (estado == FALHA);

endmodule

// File: tb/tb_controle_enchimento.sv
// Randomized bench for controle_enchimento: a window-based reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares against the DUT.
`timescale 1ns/1ps
module tb_controle_enchimento;

    localparam int DEBOUNCE = 4;
    localparam int T_PAUSA  = 8;
    localparam int T_ENCHER = 32;

    localparam int ESP = 0;
    localparam int OCI = 1;
    localparam int ENC = 2;
    localparam int FAL = 3;
    localparam int MAN = 4;

    logic       clock       = 1'b0;
    logic       reset_n     = 1'b0;
    logic       nivel_baixo = 1'b0;
    logic       nivel_alto  = 1'b0;
    logic       manual      = 1'b0;
    logic       reconhece   = 1'b0;
    logic       abre_auto;
    logic       fecha_auto;
    logic       alarme;
    logic [1:0] falha_cod;
    logic [2:0] estado;

    controle_enchimento #(
        .DEBOUNCE (DEBOUNCE),
        .T_PAUSA  (T_PAUSA),
        .T_ENCHER (T_ENCHER)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .nivel_baixo (nivel_baixo),
        .nivel_alto  (nivel_alto),
        .manual      (manual),
        .reconhece   (reconhece),
        .abre_auto   (abre_auto),
        .fecha_auto  (fecha_auto),
        .alarme      (alarme),
        .falha_cod   (falha_cod),
        .estado      (estado)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] got;

    assign got = {estado, abre_auto, fecha_auto, alarme, falha_cod};

    // ---------------- reference model ----------------
    int         m_st     = ESP;
    int         m_tempo  = 0;
    int         m_origem = ESP;
    logic [1:0] m_cod    = 2'b00;
    bit         m_fb     = 1'b0;
    bit         m_fa     = 1'b0;
    bit         q_b[$];
    bit         q_a[$];
    bit         q_m[$];
    bit         q_r[$];
    bit         w_b[$];
    bit         w_a[$];

    function automatic logic [7:0] saida(int st, logic [1:0] cod);
        logic [2:0] e;
        e = 3'(st);
        return {e, st == ENC, (st == ESP) || (st == OCI) || (st == FAL), st == FAL, cod};
    endfunction

    // True when the last DEBOUNCE synchronized samples all disagree with the filtered value.
    function automatic bit janela_oposta(bit w[$], bit f);
        if (w.size() < DEBOUNCE) return 1'b0;
        foreach (w[i]) if (w[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelo_reset();
        m_st = ESP; m_tempo = 0; m_origem = ESP; m_cod = 2'b00;
        m_fb = 1'b0; m_fa = 1'b0;
        q_b = '{1'b0, 1'b0}; q_a = '{1'b0, 1'b0};
        q_m = '{1'b0, 1'b0}; q_r = '{1'b0, 1'b0};
        w_b.delete(); w_a.delete();
    endtask

    task automatic modelo_passo();
        bit         sb, sa, sm, sr, incons;
        int         prox;
        logic [1:0] cod;
        // Raw inputs take two edges to reach the logic.
        q_b.push_back(nivel_baixo); sb = q_b.pop_front();
        q_a.push_back(nivel_alto);  sa = q_a.pop_front();
        q_m.push_back(manual);      sm = q_m.pop_front();
        q_r.push_back(reconhece);   sr = q_r.pop_front();
        incons = m_fa && !m_fb;
        prox = m_st;
        cod  = m_cod;
        if (sm) begin
            prox = MAN;
        end else if (m_st == ESP) begin
            if (m_tempo == T_PAUSA - 1) begin
                if (incons) begin prox = FAL; cod = 2'b10; end
                else prox = m_fb ? OCI : ENC;
            end
        end else if (m_st == OCI) begin
            if (incons) begin prox = FAL; cod = 2'b10; end
            else if (!m_fb) prox = ENC;
        end else if (m_st == ENC) begin
            if (incons) begin prox = FAL; cod = 2'b10; end
            else if (m_fa) prox = ESP;
            else if (m_tempo == T_ENCHER - 1) begin prox = FAL; cod = 2'b01; end
        end else if (m_st == FAL) begin
            if (sr && !incons) begin prox = ESP; cod = 2'b00; end
        end else begin
            prox = ESP;
        end
        if (prox == MAN && m_st != MAN) m_origem = m_st;
        if (m_st == MAN && prox != MAN && m_origem == FAL) cod = 2'b00;
        m_tempo = (prox == m_st) ? m_tempo + 1 : 0;
        m_st    = prox;
        m_cod   = cod;
        w_b.push_back(sb); if (w_b.size() > DEBOUNCE) void'(w_b.pop_front());
        w_a.push_back(sa); if (w_a.size() > DEBOUNCE) void'(w_a.pop_front());
        if (janela_oposta(w_b, m_fb)) m_fb = !m_fb;
        if (janela_oposta(w_a, m_fa)) m_fa = !m_fa;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            modelo_reset();
            exp_q.delete();
        end else begin
            modelo_passo();
            exp_q.push_back(saida(m_st, m_cod));
        end
    end

    // ---------------- monitor ----------------
    task automatic compara(logic [7:0] exp, string nome);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got {estado,abre,fecha,alarme,cod}=%b expected %b",
                      nome, $time, got, exp);
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            compara(8'b000_0_1_0_00, "reset_state");
        end else if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty t=%0t got %b expected a queued entry", $time, got);
        end else begin
            compara(exp_q.pop_front(), "outputs");
        end
        n_checks++;
        if (!(abre_auto && fecha_auto)) n_pass++;
        else $display("FAIL open_close_exclusive t=%0t abre=%b fecha=%b expected not both 1",
                      $time, abre_auto, fecha_auto);
    end

    // ---------------- driver ----------------
    task automatic ciclos(int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic pulso_reconhece(int n);
        reconhece = 1'b1;
        ciclos(n);
        reconhece = 1'b0;
    endtask

    initial begin
        int nivel;
        ciclos(3);
        reset_n = 1'b1;
        ciclos(12);                                  // ESPERA -> ENCHENDO
        nivel_baixo = 1'b1; ciclos(10);
        nivel_alto  = 1'b1; ciclos(10);              // fill completes -> ESPERA
        ciclos(12);                                  // -> OCIOSO
        nivel_baixo = 1'b0; ciclos(10);              // inconsistent -> FALHA(10)
        pulso_reconhece(3); ciclos(2);               // ignored while inconsistent
        nivel_alto = 1'b0; ciclos(10);
        pulso_reconhece(3);                          // -> ESPERA
        ciclos(12);                                  // -> ENCHENDO with sensors low
        ciclos(40);                                  // timeout -> FALHA(01)
        pulso_reconhece(3);
        ciclos(12);                                  // back in ENCHENDO
        nivel_alto = 1'b1; ciclos(3); nivel_alto = 1'b0; ciclos(10);  // short glitch
        manual = 1'b1; ciclos(5); manual = 1'b0; ciclos(12);
        ciclos(40);                                  // timeout again
        manual = 1'b1; ciclos(5); manual = 1'b0; ciclos(12);          // override out of FALHA
        ciclos(5);
        #2 reset_n = 1'b0;                           // async reset mid-fill
        ciclos(2);
        reset_n = 1'b1;
        ciclos(12);
        for (int k = 0; k < 150; k++) begin
            nivel = int'($urandom_range(0, 5));
            nivel_baixo = (nivel == 1) || (nivel == 2) || (nivel == 4);
            nivel_alto  = (nivel == 2) || (nivel == 5);
            manual      = ($urandom_range(0, 11) == 0);
            reconhece   = ($urandom_range(0, 2) == 0);
            ciclos(int'($urandom_range(1, 15)));
        end
        manual = 1'b0;
        ciclos(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
